// File: rtl/reg_scoreboard_pkg.sv
// Shared sizing for the register scoreboard and its hazard checker.
//   DISPATCH_WIDTH : dispatch / writeback slots per cycle
//   NUM_REGS       : architectural registers (x0 hardwired zero)
//   NUM_REGS_WIDTH : register address width
package reg_scoreboard_pkg;

   localparam int unsigned DISPATCH_WIDTH = 2;
   localparam int unsigned NUM_REGS       = 32;
   localparam int unsigned NUM_REGS_WIDTH = $clog2(NUM_REGS);

endpackage : reg_scoreboard_pkg

// File: rtl/reg_hazard_check.sv
// Combinational hazard check for one dispatch slot.
// Ports:
//   busy_i      : registered busy bit per register
//   rs1_i/_use  : source 1 address and whether it is read
//   rs2_i/_use  : source 2 address and whether it is read
//   rd_i/rd_wen : destination address and write enable
//   older_rd_i  : rd fields of every slot in the bundle
//   older_wen_i : rd_wen of strictly older slots only (younger bits are zero)
//   hazard_o    : slot must not issue this cycle
module reg_hazard_check #(
   parameter int unsigned NUM_REGS       = reg_scoreboard_pkg::NUM_REGS,
   parameter int unsigned NUM_REGS_WIDTH = $clog2(NUM_REGS)
) (
   input  logic [NUM_REGS-1:0]                                                busy_i,
   input  logic [NUM_REGS_WIDTH-1:0]                                          rs1_i,
   input  logic                                                               rs1_use_i,
   input  logic [NUM_REGS_WIDTH-1:0]                                          rs2_i,
   input  logic                                                               rs2_use_i,
   input  logic [NUM_REGS_WIDTH-1:0]                                          rd_i,
   input  logic                                                               rd_wen_i,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0][NUM_REGS_WIDTH-1:0] older_rd_i,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0]                      older_wen_i,
   output logic                                                               hazard_o
);
   import reg_scoreboard_pkg::*;

   localparam int unsigned DW = DISPATCH_WIDTH;

   logic rs1_chk;
   logic rs2_chk;
   logic rd_chk;

   // Operands on x0 never participate in any hazard.
   assign rs1_chk = rs1_use_i && (rs1_i != '0);
   assign rs2_chk = rs2_use_i && (rs2_i != '0);
   assign rd_chk  = rd_wen_i  && (rd_i  != '0);

   // RAW/WAW against the registered busy bits, then against older slots in the bundle.
   always_comb begin
      hazard_o = (rs1_chk && busy_i[rs1_i]) ||
                 (rs2_chk && busy_i[rs2_i]) ||
                 (rd_chk  && busy_i[rd_i]);
      for (int unsigned j = 0; j < DW; j++) begin
         if (older_wen_i[j] && (older_rd_i[j] != '0)) begin
            if ((rs1_chk && (older_rd_i[j] == rs1_i)) ||
                (rs2_chk && (older_rd_i[j] == rs2_i)) ||
                (rd_chk  && (older_rd_i[j] == rd_i))) begin
               hazard_o = 1'b1;
            end
         end
      end
   end

endmodule : reg_hazard_check

// File: rtl/reg_scoreboard.sv
// In-order issue gate in front of the architectural register file.
// Tracks a busy bit per register with an outstanding write and lets a
// dispatch bundle issue in order only while its operands are committed.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   disp_*_i            : per-slot dispatch fields
//   issue_fire_o        : per-slot issue strobe (combinational)
//   wb_rd_i / wb_wen_i  : writeback ports, shared with the regfile write side
//   flush_i             : squash everything in flight
//   busy_vec_o          : registered busy bits
//   stall_cnt_o         : saturating count of cycles slot 0 was held back
module reg_scoreboard #(
   parameter int unsigned NUM_REGS       = reg_scoreboard_pkg::NUM_REGS,
   parameter int unsigned NUM_REGS_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                                                               clk,
   input  logic                                                               rst,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0]                      disp_valid_i,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0][NUM_REGS_WIDTH-1:0] disp_rs1_i,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0]                      disp_rs1_use_i,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0][NUM_REGS_WIDTH-1:0] disp_rs2_i,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0]                      disp_rs2_use_i,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0][NUM_REGS_WIDTH-1:0] disp_rd_i,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0]                      disp_rd_wen_i,
   output logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0]                      issue_fire_o,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0][NUM_REGS_WIDTH-1:0] wb_rd_i,
   input  logic [reg_scoreboard_pkg::DISPATCH_WIDTH-1:0]                      wb_wen_i,
   input  logic                                                               flush_i,
   output logic [NUM_REGS-1:0]                                                busy_vec_o,
   output logic [31:0]                                                        stall_cnt_o
);
   import reg_scoreboard_pkg::*;

   localparam int unsigned DW      = DISPATCH_WIDTH;
   localparam int unsigned STALL_W = 32;

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [STALL_W-1:0]  stall_q;
   logic [STALL_W-1:0]  stall_d;
   logic [DW-1:0]       hazard;
   logic [DW-1:0]       fire;

   // Per-slot hazard; each slot only sees destinations of strictly older slots.
   for (genvar i = 0; i < DW; i++) begin : g_slot
      localparam logic [DW-1:0] OLDER_MASK = DW'((64'(1) << i) - 64'(1));

      reg_hazard_check #(
         .NUM_REGS       (NUM_REGS),
         .NUM_REGS_WIDTH (NUM_REGS_WIDTH)
      ) u_hazard (
         .busy_i      (busy_q),
         .rs1_i       (disp_rs1_i[i]),
         .rs1_use_i   (disp_rs1_use_i[i]),
         .rs2_i       (disp_rs2_i[i]),
         .rs2_use_i   (disp_rs2_use_i[i]),
         .rd_i        (disp_rd_i[i]),
         .rd_wen_i    (disp_rd_wen_i[i]),
         .older_rd_i  (disp_rd_i),
         .older_wen_i (disp_rd_wen_i & OLDER_MASK),
         .hazard_o    (hazard[i])
      );
   end

   // In-order issue chain: the first blocked slot blocks every younger one.
   always_comb begin
      logic chain;
      fire  = '0;
      chain = !rst && !flush_i;
      for (int unsigned i = 0; i < DW; i++) begin
         chain   = chain && disp_valid_i[i] && !hazard[i];
         fire[i] = chain;
      end
   end

   assign issue_fire_o = fire;

   // Next busy: writebacks clear first, issuing destinations then set (set wins).
   always_comb begin
      busy_d  = busy_q;
      stall_d = stall_q;
      if (flush_i) begin
         busy_d = '0;
      end else begin
         for (int unsigned k = 0; k < DW; k++) begin
            if (wb_wen_i[k]) begin
               busy_d[wb_rd_i[k]] = 1'b0;
            end
         end
         for (int unsigned i = 0; i < DW; i++) begin
            if (fire[i] && disp_rd_wen_i[i]) begin
               busy_d[disp_rd_i[i]] = 1'b1;
            end
         end
         busy_d[0] = 1'b0;
         if (disp_valid_i[0] && !fire[0] && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
         end
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q  <= '0;
         stall_q <= '0;
      end else begin
         busy_q  <= busy_d;
         stall_q <= stall_d;
      end
   end

   assign busy_vec_o  = busy_q;
   assign stall_cnt_o = stall_q;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random
// bundles, checked against a set-based model of the issue rules.
module tb_reg_scoreboard;
   import reg_scoreboard_pkg::*;

   localparam int unsigned DW = DISPATCH_WIDTH;
   localparam int unsigned NR = NUM_REGS;
   localparam int unsigned AW = NUM_REGS_WIDTH;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [DW-1:0]         disp_valid;
   logic [DW-1:0][AW-1:0] disp_rs1;
   logic [DW-1:0]         disp_rs1_use;
   logic [DW-1:0][AW-1:0] disp_rs2;
   logic [DW-1:0]         disp_rs2_use;
   logic [DW-1:0][AW-1:0] disp_rd;
   logic [DW-1:0]         disp_rd_wen;
   logic [DW-1:0]         issue_fire;
   logic [DW-1:0][AW-1:0] wb_rd;
   logic [DW-1:0]         wb_wen;
   logic                  flush;
   logic [NR-1:0]         busy_vec;
   logic [31:0]           stall_cnt;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk            (clk),
      .rst            (rst),
      .disp_valid_i   (disp_valid),
      .disp_rs1_i     (disp_rs1),
      .disp_rs1_use_i (disp_rs1_use),
      .disp_rs2_i     (disp_rs2),
      .disp_rs2_use_i (disp_rs2_use),
      .disp_rd_i      (disp_rd),
      .disp_rd_wen_i  (disp_rd_wen),
      .issue_fire_o   (issue_fire),
      .wb_rd_i        (wb_rd),
      .wb_wen_i       (wb_wen),
      .flush_i        (flush),
      .busy_vec_o     (busy_vec),
      .stall_cnt_o    (stall_cnt)
   );

   int          n_chk  = 0;
   int          n_pass = 0;
   bit          m_busy [NR];
   logic [31:0] m_stall;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // A slot may issue if every register it touches is outside the pending set,
   // where pending = outstanding writes plus destinations of older bundle slots.
   function automatic logic [DW-1:0] model_fire();
      bit            pend [NR];
      bit            ok;
      logic [DW-1:0] f;
      pend = m_busy;
      ok   = !rst && !flush;
      f    = '0;
      for (int i = 0; i < DW; i++) begin
         bit haz;
         haz = (disp_rs1_use[i] && disp_rs1[i] != 0 && pend[disp_rs1[i]]) ||
               (disp_rs2_use[i] && disp_rs2[i] != 0 && pend[disp_rs2[i]]) ||
               (disp_rd_wen[i]  && disp_rd[i]  != 0 && pend[disp_rd[i]]);
         ok   = ok && disp_valid[i] && !haz;
         f[i] = ok;
         if (disp_rd_wen[i] && disp_rd[i] != 0) pend[disp_rd[i]] = 1'b1;
      end
      return f;
   endfunction

   task automatic model_update(input logic [DW-1:0] f);
      if (rst) begin
         foreach (m_busy[r]) m_busy[r] = 1'b0;
         m_stall = 0;
      end else if (flush) begin
         foreach (m_busy[r]) m_busy[r] = 1'b0;
      end else begin
         for (int k = 0; k < DW; k++) if (wb_wen[k]) m_busy[wb_rd[k]] = 1'b0;
         for (int i = 0; i < DW; i++)
            if (f[i] && disp_rd_wen[i] && disp_rd[i] != 0) m_busy[disp_rd[i]] = 1'b1;
         if (disp_valid[0] && !f[0] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      end
   endtask

   function automatic logic [NR-1:0] model_busy_vec();
      logic [NR-1:0] v;
      for (int r = 0; r < NR; r++) v[r] = m_busy[r];
      return v;
   endfunction

   task automatic idle();
      disp_valid = '0; disp_rs1 = '0; disp_rs1_use = '0; disp_rs2 = '0;
      disp_rs2_use = '0; disp_rd = '0; disp_rd_wen = '0;
      wb_rd = '0; wb_wen = '0; flush = 1'b0;
   endtask

   task automatic expect_fire(input string tag, input logic [DW-1:0] exp);
      #1;
      check({tag, "/fire_const"}, 64'(issue_fire), 64'(exp));
   endtask

   // One cycle: check issue against the model, clock, then check state.
   task automatic step(input string tag);
      logic [DW-1:0] f;
      #1;
      f = model_fire();
      check({tag, "/fire"}, 64'(issue_fire), 64'(f));
      model_update(f);
      @(posedge clk);
      #1;
      check({tag, "/busy"}, 64'(busy_vec), 64'(model_busy_vec()));
      check({tag, "/stall"}, 64'(stall_cnt), 64'(m_stall));
   endtask

   initial begin
      foreach (m_busy[r]) m_busy[r] = 1'b0;
      m_stall = 0;
      idle();
      rst = 1'b1;
      step("reset");
      step("reset2");
      check("reset/busy_zero", 64'(busy_vec), 64'd0);
      rst = 1'b0;

      // Independent bundle issues fully.
      disp_valid = 2'b11; disp_rd[0] = 5'd5; disp_rd_wen[0] = 1'b1;
      disp_rs1[1] = 5'd6; disp_rs1_use[1] = 1'b1;
      expect_fire("indep", 2'b11);
      step("indep");
      check("indep/busy5", 64'(busy_vec), 64'h20);

      // RAW on busy 5 stalls until writeback, then issues next cycle.
      idle(); disp_valid = 2'b01; disp_rs1[0] = 5'd5; disp_rs1_use[0] = 1'b1;
      repeat (3) step("raw_stall");
      check("raw/stall_cnt", 64'(stall_cnt), 64'd3);
      wb_wen[0] = 1'b1; wb_rd[0] = 5'd5;
      expect_fire("raw_wb", 2'b00);
      step("raw_wb");
      wb_wen = '0;
      expect_fire("raw_after", 2'b01);
      step("raw_after");

      // Intra-bundle RAW: slot1 blocked, then stalls alone until wb of 7.
      idle(); disp_valid = 2'b11; disp_rd[0] = 5'd7; disp_rd_wen[0] = 1'b1;
      disp_rs2[1] = 5'd7; disp_rs2_use[1] = 1'b1;
      expect_fire("intra", 2'b01);
      step("intra");
      idle(); disp_valid = 2'b01; disp_rs2[0] = 5'd7; disp_rs2_use[0] = 1'b1;
      repeat (2) step("intra_stall");
      wb_wen[0] = 1'b1; wb_rd[0] = 5'd7;
      step("intra_wb");
      wb_wen = '0;
      expect_fire("intra_after", 2'b01);
      step("intra_after");

      // x0 never hazards nor becomes busy.
      idle(); disp_valid = 2'b11; disp_rd_wen = 2'b11;
      disp_rs1_use[1] = 1'b1;
      expect_fire("x0", 2'b11);
      step("x0");
      check("x0/busy_zero", 64'(busy_vec), 64'd0);

      // Writeback and re-issue of the same rd in one cycle: set wins.
      idle(); disp_valid = 2'b01; disp_rd[0] = 5'd9; disp_rd_wen[0] = 1'b1;
      wb_wen[0] = 1'b1; wb_rd[0] = 5'd9;
      step("set_wins");
      check("set_wins/busy9", 64'(busy_vec), 64'h200);
      idle(); wb_wen[1] = 1'b1; wb_rd[1] = 5'd9;
      step("clr9");

      // Flush with 3 and 4 busy.
      idle(); disp_valid = 2'b11; disp_rd_wen = 2'b11; disp_rd[0] = 5'd3; disp_rd[1] = 5'd4;
      step("mk34");
      check("mk34/busy", 64'(busy_vec), 64'h18);
      idle(); disp_valid = 2'b11; flush = 1'b1;
      expect_fire("flush", 2'b00);
      step("flush");
      check("flush/busy_zero", 64'(busy_vec), 64'd0);
      idle(); wb_wen[0] = 1'b1; wb_rd[0] = 5'd3;
      step("stale_wb");
      check("stale_wb/busy_zero", 64'(busy_vec), 64'd0);

      // Reset during a stall clears the stall counter.
      idle(); disp_valid = 2'b01; disp_rd[0] = 5'd10; disp_rd_wen[0] = 1'b1;
      step("mk10");
      idle(); disp_valid = 2'b01; disp_rs1[0] = 5'd10; disp_rs1_use[0] = 1'b1;
      repeat (2) step("stall10");
      rst = 1'b1;
      expect_fire("rst_mid", 2'b00);
      step("rst_mid");
      check("rst_mid/stall_zero", 64'(stall_cnt), 64'd0);
      rst = 1'b0;
      idle();

      // Random bundles over a small register window to provoke hazards.
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 99) == 0);
         flush = ($urandom_range(0, 19) == 0);
         for (int i = 0; i < DW; i++) begin
            disp_valid[i]   = ($urandom_range(0, 3) != 0);
            disp_rs1[i]     = AW'($urandom_range(0, 7));
            disp_rs1_use[i] = $urandom_range(0, 1) != 0;
            disp_rs2[i]     = AW'($urandom_range(0, 7));
            disp_rs2_use[i] = $urandom_range(0, 1) != 0;
            disp_rd[i]      = AW'($urandom_range(0, 7));
            disp_rd_wen[i]  = $urandom_range(0, 1) != 0;
            wb_rd[i]        = AW'($urandom_range(0, 7));
            wb_wen[i]       = $urandom_range(0, 1) != 0;
         end
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_reg_scoreboard

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- In-order issue gate directly upstream of the architectural register file.
- Tracks one busy bit per register with an outstanding write, checks each dispatch slot's sources and destination against it, and releases slots only when regfile reads return committed values.
- Busy bits clear on the same writeback ports that drive regfile rd_wen/addr_rd.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero and never busy.
- NUM_REGS_WIDTH, $clog2(NUM_REGS), register address width.
- DISPATCH_WIDTH, taken from the shared package (not a module parameter), number of dispatch and writeback slots.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- disp_valid  in  1 [DISPATCH_WIDTH]  slot i holds an instruction.
- disp_rs1  in  NUM_REGS_WIDTH [DISPATCH_WIDTH]  source 1 address.
- disp_rs1_use  in  1 [DISPATCH_WIDTH]  source 1 is read.
- disp_rs2  in  NUM_REGS_WIDTH [DISPATCH_WIDTH]  source 2 address.
- disp_rs2_use  in  1 [DISPATCH_WIDTH]  source 2 is read.
- disp_rd  in  NUM_REGS_WIDTH [DISPATCH_WIDTH]  destination address.
- disp_rd_wen  in  1 [DISPATCH_WIDTH]  slot writes rd.
- issue_fire  out  1 [DISPATCH_WIDTH]  slot issues this cycle; upstream advances it.
- wb_rd  in  NUM_REGS_WIDTH [DISPATCH_WIDTH]  writeback address, same as regfile addr_rd.
- wb_wen  in  1 [DISPATCH_WIDTH]  writeback strobe, same as regfile rd_wen.
- flush  in  1  pipeline flush.
- busy_vec  out  NUM_REGS  registered busy bits, for debug.
- stall_cnt  out  32  saturating count of stall cycles.

Behaviour:
- State: busy[NUM_REGS], stall_cnt.
  - rst (synchronous, wins over everything) clears both to 0.
  - While rst is high, issue_fire is all-zero.
- Per-slot hazard, combinational, uses registered busy only (no same-cycle writeback bypass):
  - RAW: (rs1_use and busy[rs1]) or (rs2_use and busy[rs2]).
  - WAW: rd_wen and busy[rd].
  - Intra-bundle: for any j < i with disp_rd_wen[j] and rd[j] != 0, slot i hazards if rd[j] matches rs1[i] (with rs1_use[i]), rs2[i] (with rs2_use[i]), or rd[i] (with rd_wen[i]).
  - Address 0 never hazards.
- In-order issue:
  - issue_fire[0] = disp_valid[0] and not hazard[0] and not flush.
  - issue_fire[i] = issue_fire[i-1] and disp_valid[i] and not hazard[i].
  - A blocked slot blocks all younger slots.
- Next busy, per register r != 0, evaluated in this order:
  - Cleared if any wb_wen[k] with wb_rd[k] == r.
  - Then set if any issue_fire[i] with disp_rd_wen[i] and disp_rd[i] == r.
  - Set wins on a same-cycle collision.
  - busy[0] is held at 0.
- Writeback to a non-busy register: no effect, no error.
- Writeback timing: the slot that writes back in cycle t has its busy bit cleared at the t/t+1 edge. A dependent instruction issues at the earliest in t+1, which is also when the regfile holds the data.
- flush:
  - Clears all busy bits next cycle; writebacks in the same cycle are irrelevant.
  - issue_fire is 0 during the flush cycle.
  - Later writebacks from squashed operations hit non-busy registers and are ignored.
- stall_cnt:
  - Increments when disp_valid[0] and not issue_fire[0] and not flush.
  - Saturates at 32'hFFFF_FFFF.
- issue_fire is purely combinational from the inputs and busy; there is no registered latency.

Decomposition:
- Shared package (parameters.sv): DISPATCH_WIDTH, NUM_REGS, NUM_REGS_WIDTH.
- One natural sub-module: reg_hazard_check.
  - Combinational, one instance per slot.
  - Inputs: busy vector, the slot's fields, and the older slots' rd/rd_wen.
  - Output: hazard.
- Busy update and issue chain stay in reg_scoreboard.

Test Plan:
- Reset, then DISPATCH_WIDTH=2, slot0 {rd=5, wen}, slot1 {rs1=6} -> issue_fire=2'b11; busy_vec[5]=1 next cycle, all other bits 0.
- With busy[5]=1, slot0 rs1=5 -> issue_fire=0 and stall_cnt increments each cycle. wb_wen[0]=1, wb_rd=5 in cycle t -> issue_fire[0]=0 in t and 1 in t+1.
- Intra-bundle: slot0 {rd=7, wen}, slot1 {rs2=7, rs2_use} -> issue_fire=2'b01. The next cycle slot1 alone stalls until writeback of 7.
- x0: slot0 {rd=0, wen}, slot1 {rs1=0, rd=0, wen} -> issue_fire=2'b11; busy_vec stays 0.
- Same-cycle writeback and re-issue of rd=9 with busy[9]=0: wb 9 and issue {rd=9} together -> busy[9]=1 next cycle (set wins).
- Flush with busy[3]=busy[4]=1 -> issue_fire=0 that cycle and busy_vec=0 next cycle. A later wb to 3 leaves busy_vec at 0. Asserting rst mid-stall zeroes stall_cnt on the next edge.
